// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART front end (tick generator,
// receiver and wrapper).
//   - Frame geometry defaults, kept in one place so the generator and the
//     receiver cannot disagree on the oversampling ratio.
//   - Receiver FSM state encoding.
package uart_pkg;

  localparam int DATA_BITS_DEF  = 8;
  localparam int OVERSAMPLE_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input.
//   clk      - destination clock
//   reset_n  - asynchronous active-low reset, both flops load RST_VAL
//   d        - asynchronous input
//   q        - synchronized output, 2 clk of latency
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, 16x oversampled.
//   clk        - system clock
//   reset_n    - asynchronous active-low reset
//   clk_enable - oversample tick (one clk wide) from the baud generator
//   rx         - asynchronous serial line, idle high
//   rx_data    - last correctly framed byte
//   rx_valid   - one-cycle pulse when rx_data is updated
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - a frame is in progress (FSM not in IDLE)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int MID        = OVERSAMPLE / 2 - 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_enable,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS) + 1;

  logic rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (rx_s)
  );

  rx_state_e             state_d,    state_q;
  logic [TICK_W-1:0]     tick_cnt_d, tick_cnt_q;
  logic [BIT_W-1:0]      bit_cnt_d,  bit_cnt_q;
  logic [DATA_BITS-1:0]  shift_d,    shift_q;
  logic [DATA_BITS-1:0]  rx_data_d,  rx_data_q;
  logic                  rx_valid_d, rx_valid_q;
  logic                  frame_err_d, frame_err_q;
  logic                  armed_d,    armed_q;
  logic [TICK_W-1:0]     tick_nxt;
  logic                  tick_last;

  assign tick_last = (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));
  assign tick_nxt  = tick_last ? '0 : tick_cnt_q + TICK_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    armed_d     = armed_q;
    // Pulses drop on the next clk whether or not a tick arrives.
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;

    if (clk_enable) begin
      unique case (state_q)
        ST_IDLE: begin
          // A high line re-arms; after a framing error the line must
          // return high before another start bit is accepted.
          if (rx_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d    = ST_START;
            tick_cnt_d = '0;
          end
        end
        ST_START: begin
          tick_cnt_d = tick_nxt;
          // The incremented count is tested so the start bit is sampled
          // MID ticks after the detecting tick (mid-bit for MID = 7).
          if (tick_nxt == TICK_W'(MID)) begin
            if (!rx_s) begin
              state_d    = ST_DATA;
              tick_cnt_d = '0;
              bit_cnt_d  = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          tick_cnt_d = tick_nxt;
          if (tick_last) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == BIT_W'(DATA_BITS - 1)) begin
              state_d    = ST_STOP;
              tick_cnt_d = '0;
            end
          end
        end
        ST_STOP: begin
          tick_cnt_d = tick_nxt;
          if (tick_last) begin
            if (rx_s) begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
              armed_d     = 1'b0;
            end
            // Returning to IDLE on the sample tick lets a start bit that
            // follows the stop bit directly be caught.
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      armed_q     <= 1'b1;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      armed_q     <= armed_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  // Shortened tick period keeps the run small; the receiver only counts
  // ticks, so behaviour in tick units is identical to the 326-clk case.
  localparam int TICK_DIV = 4;
  // Expected clk count from driving the start edge (just after a tick) to
  // seeing the pulse: T0 is the next tick, stop sample at T0+151.
  localparam int LAT = TICK_DIV * (1 + 151);

  logic       clk = 1'b0;
  logic       reset_n;
  logic       clk_enable;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  uart_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .clk_enable (clk_enable),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always #10 clk = ~clk;

  // Baud tick generator in the loop; freeze holds it completely.
  int   div = 0;
  int   cyc = 0;
  int   tick_no = 0;
  logic freeze = 1'b0;
  assign clk_enable = (div == TICK_DIV - 1) && !freeze;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!freeze) div <= (div == TICK_DIV - 1) ? 0 : div + 1;
    if (clk_enable) tick_no <= tick_no + 1;
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic       err;
    logic [7:0] data;
    int         t0;
    int         extra;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] last_good = 8'h00;
  int         n_valid = 0;
  int         n_err = 0;
  int         vt[16];

  always @(negedge clk) begin
    exp_t e;
    if (rx_valid || frame_err) begin
      if (rx_valid) begin
        if (n_valid < 16) vt[n_valid] = tick_no;
        n_valid++;
      end
      if (frame_err) n_err++;
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, rx_valid, frame_err}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, rx_valid, frame_err}, e.err ? 32'd1 : 32'd2);
        if (!e.err) begin
          chk("rx_data", rx_data, e.data);
          last_good = e.data;
        end else begin
          chk("data_hold", rx_data, last_good);
        end
        chk("stop_latency", cyc - e.t0, LAT + e.extra);
      end
    end
  end

  task automatic wait_ticks(input int n);
    int target;
    target = tick_no + n;
    while (tick_no < target) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra);
    exp_t e;
    e.err = !stop; e.data = d; e.t0 = cyc; e.extra = extra;
    sb.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv0;
    int ne0;
    reset_n = 1'b0;
    rx      = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    reset_n = 1'b1;
    wait_ticks(20);

    // Clean frame with busy tracking across its whole span.
    fork
      send_frame(8'hA5, 1'b1, 0);
      begin
        wait_ticks(1);
        chk("busy_at_t0", busy, 1'b1);
        wait_ticks(150);
        chk("busy_before_stop", busy, 1'b1);
        wait_ticks(1);
        chk("busy_after_stop", busy, 1'b0);
      end
    join
    wait_ticks(16);
    chk("cnt_a5", n_valid, 1);

    // Start-bit glitch: 3 ticks low.
    nv0 = n_valid; ne0 = n_err;
    rx = 1'b0;
    wait_ticks(3);
    chk("glitch_busy", busy, 1'b1);
    rx = 1'b1;
    wait_ticks(5);
    chk("glitch_idle", busy, 1'b0);
    wait_ticks(40);
    chk("glitch_no_valid", n_valid, nv0);
    chk("glitch_no_err", n_err, ne0);

    // Framing error, break held low, then a good frame.
    send_frame(8'h3C, 1'b0, 0);
    rx = 1'b0;
    wait_ticks(24);
    chk("break_idle_a", busy, 1'b0);
    wait_ticks(24);
    chk("break_idle_b", busy, 1'b0);
    chk("break_data", rx_data, 8'hA5);
    chk("cnt_err", n_err, ne0 + 1);
    rx = 1'b1;
    wait_ticks(16);
    send_frame(8'h81, 1'b1, 0);
    wait_ticks(16);

    // Back-to-back frames, no idle gap.
    nv0 = n_valid;
    send_frame(8'h00, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 0);
    wait_ticks(8);
    chk("b2b_count", n_valid, nv0 + 2);
    if (n_valid >= nv0 + 2 && nv0 + 1 < 16)
      chk("b2b_gap", vt[nv0 + 1] - vt[nv0], 160);

    // Reset during data bit 4 of 0x5A.
    nv0 = n_valid;
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) drive_bit(8'h5A >> i);
    rx = 1'b1; // bit 4 of 0x5A
    wait_ticks(8);
    chk("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mrst_data", rx_data, 8'h00);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_valid", rx_valid, 1'b0);
    chk("mrst_err", frame_err, 1'b0);
    last_good = 8'h00;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_ticks(200);
    chk("partial_no_valid", n_valid, nv0);
    chk("partial_data", rx_data, 8'h00);
    send_frame(8'h5A, 1'b1, 0);
    wait_ticks(16);

    // Tick stream frozen for 1000 clk mid-frame.
    fork
      send_frame(8'h96, 1'b1, 1000);
      begin
        wait_ticks(70);
        freeze = 1'b1;
        repeat (1000) @(negedge clk);
        freeze = 1'b0;
      end
    join
    wait_ticks(16);

    chk("total_valid", n_valid, 6);
    chk("total_err", n_err, 1);
    chk("sb_empty", sb.size(), 0);
    chk("final_data", rx_data, 8'h96);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
